// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR of two WIDTH-bit operands,
// one SLICE-bit slice per clock, with valid/ready handshakes on both sides.
module logic_unit_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;

  int               base;
  logic [SLICE-1:0] sa, sb, sr;
  logic [WIDTH-1:0] nxt;

  // nxt is the result with the current slice merged in, so zero can be
  // derived from the complete value on the same edge the last slice lands.
  always_comb begin
    base = SLICE * int'(cnt);
    sa   = a_q[base +: SLICE];
    sb   = b_q[base +: SLICE];
    case (op_q)
      2'b00:   sr = sa & sb;
      2'b01:   sr = sa | sb;
      2'b10:   sr = sa ^ sb;
      default: sr = ~(sa | sb);
    endcase
    nxt = result;
    nxt[base +: SLICE] = sr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            result   <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          result <= nxt;
          if (cnt == LAST) begin
            zero      <= (nxt == '0);
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
